segregate_tick_rand: RTL
========================

# segregate_tick_rand

Timing and randomness source for the Segregate game controller. It produces the one-cycle `Pulse` that forces a SKIP when the player is too slow, and the `rand` bit that picks each item's colour. The pulse period shortens as `score` grows. It sits directly upstream of the game state machine, and takes `score` back from it as feedback.

## Interface
Parameters:
- `CNT_W`, 27: width of the period counter and of the period arithmetic.
- `BASE_PERIOD`, 50_000_000: tick period in clocks at level 0 (0.5 s at 100 MHz).
- `STEP`, 2_500_000: period reduction per level.
- `MIN_PERIOD`, 10_000_000: floor on the period. Must be ≥ 2.
- `SEED`, 16'hACE1: LFSR reset value. If `SEED` is 0, the block uses 16'hACE1 instead.

Ports:
- `Clk`, input, 1: system clock.
- `Reset`, input, 1: asynchronous, active-high reset.
- `Run`, input, 1: high while the game is in the PLAY/LEFT/RIGHT/SKIP states.
- `Clear`, input, 1: one-cycle strobe on a player move (LEFT/RIGHT). Restarts the period.
- `score`, input, 7: current score from the game FSM.
- `Pulse`, output, 1: registered one-cycle timeout strobe.
- `rand`, output, 1: registered random bit, `lfsr[0]`.
- `level`, output, 4: registered current speed level.

## Operation
- Reset values: `Pulse`=0, `rand`=`SEED[0]`, `level`=0, count=0, lfsr=`SEED`. Use the substituted 16'hACE1 if `SEED` is 0.
- LFSR:
  - 16-bit Galois, right shift, mask 16'hB400 (x^16+x^14+x^13+x^11+1).
  - Update rule: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances every clock regardless of `Run`, so the player's timing supplies the entropy.
  - Period is 65535 and it never reaches 0.
- Level: `level` = `score[6:3]` (score/8), registered each clock. Range 0–15.
- Period:
  - period = max(`BASE_PERIOD` − `level`×`STEP`, `MIN_PERIOD`).
  - Compute in `CNT_W`+4 bits as a signed compare so an underflow clamps to `MIN_PERIOD`.
  - Recomputed combinationally from the registered `level`.
- Counter priority, evaluated each clock:
  1. `Run`=0: count←0, `Pulse`←0.
  2. `Clear`=1: count←0, `Pulse`←0. `Clear` wins over terminal count.
  3. count ≥ period−1: count←0, `Pulse`←1.
  4. Otherwise: count←count+1, `Pulse`←0.
- The ≥ compare handles a period shrinking below the current count. The pulse fires on the next clock, with no wrap to 2^`CNT_W`.
- Reset mid-operation returns every register to its reset value immediately, without waiting for a clock edge.

## Timing
- `Pulse` is high for exactly one clock.
- The first `Pulse` is high in the cycle following the `period`-th rising edge that samples `Run`=1, counting that edge as 1. Subsequent pulses are spaced every `period` clocks while `Run`=1 and no `Clear` arrives.
- After `Clear` is sampled at edge k, the next `Pulse` is high after edge k+`period`.
- `score` to `level` latency: 1 clock. `level` to effective period: 0 clocks.
- `rand` changes every clock. The game FSM samples it on its own state edges.

## Configuration
- `TICK_SPEEDUP_EN` defined: period scales with `level` as described above.
- `TICK_SPEEDUP_EN` undefined:
  - period is fixed at `BASE_PERIOD`.
  - the `level` output is tied to 0.
  - `score` is ignored.
  - LFSR and `Clear` behaviour are unchanged.

## Test plan
All scenarios use `BASE_PERIOD`=20, `STEP`=2, `MIN_PERIOD`=8, `SEED`=16'h0001, with `TICK_SPEEDUP_EN` defined unless stated.
- Reset asserted with `Run`=0 → `Pulse`=0, `level`=0, `rand`=1. After 1 clock, lfsr=16'hB400 and `rand`=0. After 65535 clocks, lfsr=16'h0001 again.
- `Run`=1, `score`=0 → `Pulse` high after edges 20, 40, 60, each exactly 1 cycle wide. `Run`=0 at edge 30 → no further pulses.
- `score`=16 → `level`=2, period 16. `score`=127 → `level`=15, 20−30 clamps to period 8.
- `Clear` at edge 10 → next `Pulse` after edge 30. `Clear` coincident with count=19 → no pulse, count restarts at 0.
- Count=15 at period 20, then `score` jumps 0→127 → `Pulse` fires on the next clock, and afterwards every 8 clocks.
- `TICK_SPEEDUP_EN` undefined, `score`=127 → period stays 20, `level`=0. Async `Reset` mid-count → `Pulse`=0 and count=0 immediately.

Source files
------------

// File: rtl/segregate_tick_rand_if.sv
// Game-FSM <-> tick/random source signals. The random bit is named rand_bit
// because "rand" is a reserved SystemVerilog keyword.
interface segregate_tick_rand_if;
  logic       Run;
  logic       Clear;
  logic [6:0] score;
  logic       Pulse;
  logic       rand_bit;
  logic [3:0] level;

  modport master (output Run, Clear, score, input Pulse, rand_bit, level);
  modport slave  (input Run, Clear, score, output Pulse, rand_bit, level);
endinterface

// File: rtl/segregate_tick_rand.sv
// Timeout pulse (period shrinking with score when TICK_SPEEDUP_EN is defined)
// plus a free-running 16-bit Galois LFSR random bit for the Segregate game.
module segregate_tick_rand #(
  parameter int          CNT_W       = 27,
  parameter int          BASE_PERIOD = 50_000_000,
  parameter int          STEP        = 2_500_000,
  parameter int          MIN_PERIOD  = 10_000_000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic                  Clk,
  input logic                  Reset,
  segregate_tick_rand_if.slave tick
);

  // An all-zero seed would lock the LFSR up, so fall back to the default.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  logic [15:0]      lfsr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period;
  logic             pulse_q;
  logic [3:0]       level_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

`ifdef TICK_SPEEDUP_EN
  localparam int                    W     = CNT_W + 4;
  localparam logic signed [W-1:0]   MIN_S = W'(MIN_PERIOD);

  logic signed [W-1:0] diff;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      level_q <= 4'd0;
    end else begin
      level_q <= tick.score[6:3];
    end
  end

  // Signed, widened arithmetic so a large level clamps instead of wrapping.
  always_comb begin
    diff   = W'(BASE_PERIOD) - (W'(STEP) * W'(level_q));
    period = (diff < MIN_S) ? CNT_W'(MIN_PERIOD) : diff[CNT_W-1:0];
  end
`else
  logic unused_score;

  assign unused_score = ^tick.score;
  assign level_q      = 4'd0;
  assign period       = CNT_W'(BASE_PERIOD);
`endif

  // >= rather than == so a period that shrinks under the count fires next clock.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count   <= '0;
      pulse_q <= 1'b0;
    end else if (!tick.Run || tick.Clear) begin
      count   <= '0;
      pulse_q <= 1'b0;
    end else if (count >= period - CNT_W'(1)) begin
      count   <= '0;
      pulse_q <= 1'b1;
    end else begin
      count   <= count + CNT_W'(1);
      pulse_q <= 1'b0;
    end
  end

  assign tick.Pulse    = pulse_q;
  assign tick.rand_bit = lfsr[0];
  assign tick.level    = level_q;

endmodule
